// File: rtl/vx_mem_responder.sv
// ============================================================================
// Module   : vx_mem_responder
// Brief    : Memory-side endpoint with an internal RAM, a fixed read latency
//            and a credit-guarded, in-order response queue.
//            Define VX_MEM_RESPONDER_WRITE_ACK_EN to make writes return a
//            response (tag echoed, zero data).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_mem_responder #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 8,
  parameter int TAG_WIDTH      = 8,
  parameter int LATENCY        = 2,
  parameter int RSP_QUEUE_SIZE = 4,
  parameter int DATA_SIZE      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_rw,
  input  logic [DATA_SIZE-1:0]  req_byteen,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_ready
);

  localparam int c_PEND_W = $clog2(RSP_QUEUE_SIZE + 1);
  localparam int c_PTR_W  = (RSP_QUEUE_SIZE > 1) ? $clog2(RSP_QUEUE_SIZE) : 1;
  localparam logic [c_PEND_W-1:0] c_QSIZE    = c_PEND_W'(RSP_QUEUE_SIZE);
  localparam logic [c_PTR_W-1:0]  c_PTR_LAST = c_PTR_W'(RSP_QUEUE_SIZE - 1);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [TAG_WIDTH-1:0]  r_fifo_tag  [RSP_QUEUE_SIZE];
  logic [DATA_WIDTH-1:0] r_fifo_data [RSP_QUEUE_SIZE];
  logic [c_PEND_W-1:0]   r_pending;
  logic [c_PEND_W-1:0]   r_count;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;

  logic                  w_accept;
  logic                  w_produce;
  logic                  w_pop;
  logic                  w_push;
  logic [TAG_WIDTH-1:0]  w_push_tag;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [DATA_WIDTH-1:0] w_in_data;

  // Credits are checked against pending, so a request is only taken when its
  // response already has a guaranteed FIFO slot.
  assign req_ready = reset && (r_pending < c_QSIZE);
  assign w_accept  = req_valid && req_ready;
  assign w_pop     = rsp_valid && rsp_ready;
  assign w_in_data = req_rw ? '0 : r_mem[req_addr];

`ifdef VX_MEM_RESPONDER_WRITE_ACK_EN
  assign w_produce = w_accept;
`else
  assign w_produce = w_accept && !req_rw;
`endif

  assign rsp_valid = (r_count != '0);
  assign rsp_tag   = r_fifo_tag[r_rd_ptr];
  assign rsp_data  = r_fifo_data[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_accept && req_rw) begin
      for (int i = 0; i < DATA_SIZE; i++) begin
        if (req_byteen[i]) begin
          r_mem[req_addr][i*8 +: 8] <= req_data[i*8 +: 8];
        end
      end
    end
  end

  // The RAM read happens at the accept edge; the remaining LATENCY-1 cycles
  // are spent in this delay line before the response lands in the FIFO.
  generate
    if (LATENCY > 1) begin : g_pipe
      localparam int c_STAGES = LATENCY - 1;
      logic [c_STAGES-1:0]   r_vld;
      logic [TAG_WIDTH-1:0]  r_tag  [c_STAGES];
      logic [DATA_WIDTH-1:0] r_data [c_STAGES];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_vld <= '0;
        end else begin
          r_vld[0] <= w_produce;
          for (int s = 1; s < c_STAGES; s++) begin
            r_vld[s] <= r_vld[s-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        r_tag[0]  <= req_tag;
        r_data[0] <= w_in_data;
        for (int s = 1; s < c_STAGES; s++) begin
          r_tag[s]  <= r_tag[s-1];
          r_data[s] <= r_data[s-1];
        end
      end

      assign w_push      = r_vld[c_STAGES-1];
      assign w_push_tag  = r_tag[c_STAGES-1];
      assign w_push_data = r_data[c_STAGES-1];
    end else begin : g_direct
      assign w_push      = w_produce;
      assign w_push_tag  = req_tag;
      assign w_push_data = w_in_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_tag[r_wr_ptr]  <= w_push_tag;
      r_fifo_data[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pending <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case ({w_produce, w_pop})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vx_mem_responder.sv
// ============================================================================
// Module   : tb_vx_mem_responder
// Brief    : Directed and random bench for vx_mem_responder against a
//            queue-based model of in-order responses with fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vx_mem_responder;

  localparam int c_LAT = 2;
  localparam int c_QSZ = 4;
`ifdef VX_MEM_RESPONDER_WRITE_ACK_EN
  localparam bit c_WACK = 1'b1;
`else
  localparam bit c_WACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_tag = '0;
  logic [7:0]  req_addr = '0;
  logic        req_rw = 1'b0;
  logic [7:0]  req_byteen = '0;
  logic [63:0] req_data = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_tag;
  logic [63:0] rsp_data;
  logic        rsp_ready = 1'b0;

  always #5 clk = ~clk;

  vx_mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_tag    (req_tag),
    .req_addr   (req_addr),
    .req_rw     (req_rw),
    .req_byteen (req_byteen),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_tag    (rsp_tag),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready)
  );

  typedef struct {
    logic [7:0]  tag;
    logic [63:0] data;
    int          due;
  } rsp_t;

  rsp_t        q[$];
  logic [63:0] mm [256];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          s_cyc;
  logic        obs_valid, obs_ready;
  logic [7:0]  obs_tag;
  logic [63:0] obs_data;
  bit          req_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: compare against the model at the falling edge, then advance
  // the model with whatever fired and return just after the rising edge.
  task automatic tick();
    bit   exp_valid, exp_ready, rsp_fire;
    rsp_t e;
    @(negedge clk);
    obs_valid = rsp_valid;
    obs_ready = req_ready;
    obs_tag   = rsp_tag;
    obs_data  = rsp_data;
    s_cyc     = cyc;
    exp_valid = reset && (q.size() > 0) && (q[0].due <= cyc);
    exp_ready = reset && (q.size() < c_QSZ);
    chk("req_ready", obs_ready, exp_ready);
    chk("rsp_valid", obs_valid, exp_valid);
    if (exp_valid) begin
      chk("rsp_tag", obs_tag, q[0].tag);
      chk("rsp_data", obs_data, q[0].data);
    end
    req_acc  = req_valid && exp_ready;
    rsp_fire = exp_valid && rsp_ready;
    if (rsp_fire) void'(q.pop_front());
    if (req_acc) begin
      e.tag = req_tag;
      e.due = cyc + c_LAT;
      if (req_rw) begin
        for (int b = 0; b < 8; b++)
          if (req_byteen[b]) mm[req_addr][b*8 +: 8] = req_data[b*8 +: 8];
        e.data = '0;
        if (c_WACK) q.push_back(e);
      end else begin
        e.data = mm[req_addr];
        q.push_back(e);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit rw, input logic [7:0] addr, input logic [7:0] tag,
                        input logic [7:0] be, input logic [63:0] data, output int t_acc);
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_tag = tag;
    req_byteen = be; req_data = data;
    t_acc = -1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (req_acc) begin
        t_acc = s_cyc;
        break;
      end
    end
    req_valid = 1'b0;
    vectors++;
    assert (t_acc >= 0) else begin
      miscompares++;
      $error("FAIL req_accept_timeout: observed %0d expected >=0", t_acc);
    end
  endtask

  task automatic wait_rsp(input logic [7:0] etag, input logic [63:0] edata, input int t_acc);
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("rsp_seen", found, 1'b1);
    if (found) begin
      chk("rsp_latency", 64'(s_cyc - t_acc), c_LAT);
      chk("rsp_tag_directed", obs_tag, etag);
      chk("rsp_data_directed", obs_data, edata);
    end
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int t, n_acc, nrsp, first, last, got;
    bit flag;

    // Reset held low
    tick();
    chk("reset_rsp_valid", obs_valid, 1'b0);
    chk("reset_req_ready", obs_ready, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_ready", obs_ready, 1'b1);

    rsp_ready = 1'b1;
    for (int a = 0; a < 16; a++) do_req(1'b1, 8'(a), 8'(a), 8'hFF, {$urandom, $urandom}, t);

    // Full-word then partial write
    do_req(1'b1, 8'd3, 8'h01, 8'hFF, 64'h1122334455667788, t);
    do_req(1'b0, 8'd3, 8'h5A, 8'h00, '0, t);
    wait_rsp(8'h5A, 64'h1122334455667788, t);
    do_req(1'b1, 8'd3, 8'h02, 8'h0F, 64'hAAAAAAAAAAAAAAAA, t);
    do_req(1'b0, 8'd3, 8'h5B, 8'h00, '0, t);
    wait_rsp(8'h5B, 64'h11223344AAAAAAAA, t);
    drain();

    // Backpressure: only four credits
    rsp_ready = 1'b0; req_valid = 1'b1; req_rw = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      req_tag = 8'(n_acc); req_addr = 8'(n_acc);
      tick();
      if (req_acc) n_acc++;
    end
    req_valid = 1'b0;
    chk("bp_accepted", n_acc, 4);
    chk("bp_ready_low", obs_ready, 1'b0);
    rsp_ready = 1'b1;
    got = 0; flag = 1'b0;
    for (int i = 0; i < 20 && got < 4; i++) begin
      tick();
      if (flag) begin
        chk("bp_ready_after_fire", obs_ready, 1'b1);
        flag = 1'b0;
      end
      if (obs_valid) begin
        chk("bp_order", obs_tag, 8'(got));
        if (got == 0) flag = 1'b1;
        got++;
      end
    end
    chk("bp_count", got, 4);
    drain();

    // Streaming
    req_valid = 1'b1; req_rw = 1'b0;
    n_acc = 0; nrsp = 0; first = -1; last = -1;
    for (int i = 0; i < 26; i++) begin
      if (i == 16) req_valid = 1'b0;
      req_tag = 8'(i + 8'h40); req_addr = 8'(i % 16);
      tick();
      if (i < 16) chk("stream_ready", obs_ready, 1'b1);
      if (req_acc) n_acc++;
      if (obs_valid) begin
        if (first < 0) first = s_cyc;
        last = s_cyc;
        nrsp++;
      end
    end
    chk("stream_accepted", n_acc, 16);
    chk("stream_rsp_count", nrsp, 16);
    chk("stream_contiguous", 64'(last - first), 15);
    drain();

    // Reset while three reads are in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_req(1'b0, 8'(i), 8'(8'h70 + i), 8'h00, '0, t);
    reset = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b0);
    q.delete();
    tick();
    reset = 1'b1;
    rsp_ready = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_valid) nrsp++;
    end
    chk("midrst_no_rsp", nrsp, 0);
    chk("midrst_ready", obs_ready, 1'b1);

    // Write acknowledge
    do_req(1'b1, 8'd7, 8'h11, 8'hFF, {$urandom, $urandom}, t);
`ifdef VX_MEM_RESPONDER_WRITE_ACK_EN
    wait_rsp(8'h11, 64'h0, t);
`else
    nrsp = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obs_valid) nrsp++;
    end
    chk("wack_no_rsp", nrsp, 0);
    chk("wack_ready", obs_ready, 1'b1);
`endif
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_rw     = ($urandom_range(0, 2) == 0);
      req_addr   = 8'($urandom_range(0, 15));
      req_tag    = 8'($urandom);
      req_byteen = 8'($urandom);
      req_data   = {$urandom, $urandom};
      rsp_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
